// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
//   Downstream stage of the 4-bit ALU. Each valid ALU result is stored with
//   the opcode that produced it in a show-ahead FIFO behind a valid/ready
//   handshake. A consumer that stalls does not hold up the ALU. The FIFO
//   refuses results while it is full and counts them in a saturating counter.
//
// Optional feature macro: ALU_RES_PARITY_EN
//   When defined, each entry also stores par = ^{in_op, in_res}, and the
//   out_par port presents the parity of the head entry.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   ALU result on in_op/in_res is valid this cycle
//   in_ready   FIFO can accept (not full)
//   in_op      opcode that produced in_res
//   in_res     ALU result
//   out_valid  head entry present (not empty)
//   out_ready  consumer takes the head this cycle
//   out_op     head opcode (0 when empty)
//   out_res    head result (0 when empty)
//   out_zero   head result is zero (0 when empty)
//   count      number of occupied entries, 0..DEPTH
//   drop_cnt   results refused while full; saturates at all-ones
//   out_par    head parity (only with ALU_RES_PARITY_EN; 0 when empty)
// ---------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 4,
    parameter int OPW   = 3,
    parameter int CNTW  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPW-1:0]           in_op,
    input  logic [DW-1:0]            in_res,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPW-1:0]           out_op,
    output logic [DW-1:0]            out_res,
    output logic                     out_zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNTW-1:0]          drop_cnt
`ifdef ALU_RES_PARITY_EN
    ,
    output logic                     out_par
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = OPW + DW;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Increment that holds at the all-ones value instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        if (v == {CNTW{1'b1}}) begin
            return v;
        end
        return v + CNTW'(1);
    endfunction

    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;

    logic full, empty, push, pop;
    logic [EW-1:0] head;

    // Handshake decode and next-state
    always_comb begin
        full       = (count_q == FULL_CNT);
        empty      = (count_q == '0);
        // A full FIFO refuses a push even when a pop happens the same cycle.
        push       = in_valid & ~full;
        pop        = out_ready & ~empty;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (in_valid & full) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage; contents are left alone by reset because the pointers
    // and count alone decide what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_op, in_res};
        end
    end

`ifdef ALU_RES_PARITY_EN
    logic [DEPTH-1:0] par_mem_q;

    always_ff @(posedge clk) begin
        if (push) begin
            par_mem_q[wr_ptr_q] <= ^{in_op, in_res};
        end
    end

    assign out_par = ~empty & par_mem_q[rd_ptr_q];
`endif

    // Show-ahead output, forced to zero while empty
    assign head      = mem_q[rd_ptr_q];
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign out_op    = empty ? '0 : head[DW +: OPW];
    assign out_res   = empty ? '0 : head[DW-1:0];
    assign out_zero  = ~empty & (head[DW-1:0] == '0);
    assign count     = count_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_alu_result_fifo
//   Self-checking bench for alu_result_fifo. A queue-based reference model
//   follows every cycle. A table of hand-computed vectors covers reset,
//   single transfer, fill/overflow/drain and the zero flag. Hand sequences
//   cover concurrent push/pop with pointer wrap, drop counter saturation and
//   mid-operation reset. A randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_alu_result_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = '0;
    logic [3:0] in_res = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_op;
    logic [3:0] out_res;
    logic       out_zero;
    logic [2:0] count;
    logic [7:0] drop_cnt;
`ifdef ALU_RES_PARITY_EN
    logic       out_par;
`endif

    alu_result_fifo #(.DEPTH(DEPTH), .DW(4), .OPW(3), .CNTW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_res    (in_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_res   (out_res),
        .out_zero  (out_zero),
        .count     (count),
        .drop_cnt  (drop_cnt)
`ifdef ALU_RES_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of {op,res} entries plus a saturating drop count
    logic [6:0] mq[$];
    int         mdrop = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic model_check(input int idx);
        logic [6:0] h;
        h = (mq.size() > 0) ? mq[0] : 7'd0;
        chk("m_count",  idx, 32'(count),     32'(mq.size()));
        chk("m_valid",  idx, 32'(out_valid), 32'(mq.size() > 0));
        chk("m_ready",  idx, 32'(in_ready),  32'(mq.size() < DEPTH));
        chk("m_op",     idx, 32'(out_op),    32'(h[6:4]));
        chk("m_res",    idx, 32'(out_res),   32'(h[3:0]));
        chk("m_zero",   idx, 32'(out_zero),  32'((mq.size() > 0) && (h[3:0] == 4'd0)));
        chk("m_drop",   idx, 32'(drop_cnt),  32'(mdrop));
`ifdef ALU_RES_PARITY_EN
        chk("m_par",    idx, 32'(out_par),   32'((mq.size() > 0) ? ^h : 1'b0));
`endif
    endtask

    // Drive one cycle, advance the model by the same rules, check after the edge
    task automatic step(input bit r, input bit v, input logic [2:0] o, input logic [3:0] d,
                        input bit rd, input int idx);
        bit was_full, was_empty;
        rst = r; in_valid = v; in_op = o; in_res = d; out_ready = rd;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            mdrop = 0;
        end else begin
            if (v && was_full && mdrop < 255) mdrop++;
            if (rd && !was_empty) void'(mq.pop_front());
            if (v && !was_full) mq.push_back({o, d});
        end
        model_check(idx);
    endtask

    typedef struct {
        bit         r;
        bit         v;
        logic [2:0] op;
        logic [3:0] res;
        bit         rd;
        int         e_cnt;
        bit         e_vld;
        bit         e_rdy;
        int         e_op;
        int         e_res;
        bit         e_zero;
        int         e_drop;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit v, input int op, input int res, input bit rd,
                       input int e_cnt, input bit e_vld, input bit e_rdy, input int e_op,
                       input int e_res, input bit e_zero, input int e_drop);
        vec_t t;
        t.r = r; t.v = v; t.op = 3'(op); t.res = 4'(res); t.rd = rd;
        t.e_cnt = e_cnt; t.e_vld = e_vld; t.e_rdy = e_rdy; t.e_op = e_op;
        t.e_res = e_res; t.e_zero = e_zero; t.e_drop = e_drop;
        tbl.push_back(t);
    endtask

    initial begin
        // r v op res rd | cnt vld rdy op res zero drop
        add(1,0,0,0,0,   0,0,1,0,0,0,0);   // reset, two cycles
        add(1,0,0,0,0,   0,0,1,0,0,0,0);
        add(0,0,0,0,0,   0,0,1,0,0,0,0);   // idle
        add(0,1,1,9,0,   1,1,1,1,9,0,0);   // single transfer
        add(0,0,0,0,1,   0,0,1,0,0,0,0);   // pop it
        add(0,1,2,1,0,   1,1,1,2,1,0,0);   // fill 1..4
        add(0,1,2,2,0,   2,1,1,2,1,0,0);
        add(0,1,2,3,0,   3,1,1,2,1,0,0);
        add(0,1,2,4,0,   4,1,0,2,1,0,0);
        add(0,1,2,5,0,   4,1,0,2,1,0,1);   // refused while full
        add(0,1,2,5,0,   4,1,0,2,1,0,2);
        add(0,1,2,5,0,   4,1,0,2,1,0,3);
        add(0,0,0,0,1,   3,1,1,2,2,0,3);   // drain in order
        add(0,0,0,0,1,   2,1,1,2,3,0,3);
        add(0,0,0,0,1,   1,1,1,2,4,0,3);
        add(0,0,0,0,1,   0,0,1,0,0,0,3);
        add(0,1,0,0,0,   1,1,1,0,0,1,3);   // zero result
        add(0,1,7,15,1,  1,1,1,7,15,0,3);  // pop zero entry, push F
        add(0,0,0,0,1,   0,0,1,0,0,0,3);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].op, tbl[i].res, tbl[i].rd, i);
            chk("t_count", i, 32'(count),     32'(tbl[i].e_cnt));
            chk("t_valid", i, 32'(out_valid), 32'(tbl[i].e_vld));
            chk("t_ready", i, 32'(in_ready),  32'(tbl[i].e_rdy));
            chk("t_op",    i, 32'(out_op),    32'(tbl[i].e_op));
            chk("t_res",   i, 32'(out_res),   32'(tbl[i].e_res));
            chk("t_zero",  i, 32'(out_zero),  32'(tbl[i].e_zero));
            chk("t_drop",  i, 32'(drop_cnt),  32'(tbl[i].e_drop));
        end

        // Concurrent push/pop at count=2: occupancy holds, pointers wrap
        step(0, 1, 3'd4, 4'd10, 0, 100);
        step(0, 1, 3'd4, 4'd11, 0, 101);
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 3'd5, 4'(k), 1, 110 + k);
            chk("cc_count", k, 32'(count),   32'd2);
            chk("cc_head",  k, 32'(out_res), (k == 0) ? 32'd11 : 32'(k - 1));
        end

        // Drop counter saturation: fill, then hold in_valid well past 255
        for (int k = 0; k < 4; k++) step(0, 1, 3'd1, 4'(k + 1), 0, 200 + k);
        for (int k = 0; k < 262; k++) step(0, 1, 3'd6, 4'hE, 0, 300);
        chk("sat_drop",  0, 32'(drop_cnt), 32'd255);
        chk("sat_count", 0, 32'(count),    32'd4);

        // Mid-operation reset with three entries stored
        step(0, 0, 3'd0, 4'd0, 1, 400);
        chk("pre_rst_count", 0, 32'(count), 32'd3);
        step(1, 0, 3'd0, 4'd0, 0, 401);
        chk("rst_valid", 0, 32'(out_valid), 32'd0);
        chk("rst_count", 0, 32'(count),     32'd0);
        chk("rst_drop",  0, 32'(drop_cnt),  32'd0);
        step(0, 1, 3'b011, 4'h5, 0, 402);
        chk("post_rst_res", 0, 32'(out_res), 32'd5);
        chk("post_rst_op",  0, 32'(out_op),  32'd3);
`ifdef ALU_RES_PARITY_EN
        chk("post_rst_par", 0, 32'(out_par), 32'd0);
`endif

        // Randomized traffic with phases that bias toward empty or full
        for (int i = 0; i < 3000; i++) begin
            int  phase;
            bit  r, v, rd;
            phase = (i / 400) % 4;
            r  = ($urandom_range(0, 149) == 0);
            v  = ($urandom_range(0, 3) < 3 - (phase == 1 ? 2 : 0));
            rd = ($urandom_range(0, 3) < 1 + phase);
            step(r, v, 3'($urandom), 4'($urandom), rd, 1000 + i);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
